// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the IF/ID pipeline register slice:
//   - NOP            : encoding loaded into the instruction register for bubbles
//   - ST_*           : IF/ID controller state encoding
//   - *_MSB / *_LSB  : bit positions of the MIPS-style instruction fields
// No ports (package only).
// ---------------------------------------------------------------------------
package pipeline_pkg;

    // A bubble is the all-zero word (sll $0,$0,0).
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Controller states.
    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_SQUASH = 2'd3;

    // Instruction field positions.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the IF/ID debug event counters. Updates on
// the falling clock edge so it stays aligned with the pipeline register.
// Ports:
//   clk   : clock (falling-edge active)
//   reset : asynchronous active-high reset, clears the count
//   inc   : count this edge
//   count : current value, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [width-1:0] count
);

    // Increment on request, but never wrap: once all-ones is reached the
    // counter stays there until the next reset.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/ifid_stage.sv
// ---------------------------------------------------------------------------
// ifid_stage
// IF/ID pipeline register with a small controller (FILL/RUN/HOLD/SQUASH),
// combinational field decode of the held instruction and two saturating
// debug counters (stall events, flush events).
// Ports:
//   clk             : clock, all state updates on the falling edge
//   reset           : asynchronous active-high reset
//   PC_sumado       : PC+1 from fetch
//   Instruction     : word from the instruction ROM
//   IFID_write      : 1 = capture, 0 = hold (stall)
//   flush           : discard the instruction being captured
//   PC_sumado_out   : registered PC+1
//   Instruction_out : registered instruction (NOP when not valid)
//   valid_out       : registered instruction is real
//   opcode..funct   : decoded fields of Instruction_out
//   imm_ext         : sign-extended Instruction_out[15:0]
//   stall_count     : saturating count of stall edges
//   flush_count     : saturating count of flush edges
// ---------------------------------------------------------------------------
module ifid_stage
    import pipeline_pkg::*;
#(
    parameter int width_B = 32,
    parameter int cnt_B   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [width_B-1:0] PC_sumado,
    input  logic [width_B-1:0] Instruction,
    input  logic               IFID_write,
    input  logic               flush,
    output logic [width_B-1:0] PC_sumado_out,
    output logic [width_B-1:0] Instruction_out,
    output logic               valid_out,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [width_B-1:0] imm_ext,
    output logic [cnt_B-1:0]   stall_count,
    output logic [cnt_B-1:0]   flush_count
);

    logic [1:0]         r_state;
    logic [width_B-1:0] r_pc;
    logic [width_B-1:0] r_instr;
    logic               r_valid;
    logic               w_stall_inc;
    logic               w_flush_inc;

    // The first edge after reset is the ROM priming cycle: the ROM output is
    // not yet meaningful, so a bubble is loaded along with the current PC+1
    // and both stall and flush requests are ignored. After that, flush wins
    // over stall, a stall freezes everything, and otherwise the fetched word
    // is captured as a real instruction.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FILL;
            r_pc    <= '0;
            r_instr <= width_B'(NOP);
            r_valid <= 1'b0;
        end else if (r_state == ST_FILL) begin
            r_pc    <= PC_sumado;
            r_instr <= width_B'(NOP);
            r_valid <= 1'b0;
            r_state <= ST_RUN;
        end else if (flush) begin
            r_instr <= width_B'(NOP);
            r_valid <= 1'b0;
            r_state <= ST_SQUASH;
        end else if (!IFID_write) begin
            r_state <= ST_HOLD;
        end else begin
            r_pc    <= PC_sumado;
            r_instr <= Instruction;
            r_valid <= 1'b1;
            r_state <= ST_RUN;
        end
    end

    // Event qualifiers mirror the priority above so each counter bumps on the
    // very edge that performs the matching register action.
    always_comb begin
        w_stall_inc = (r_state != ST_FILL) && !flush && !IFID_write;
        w_flush_inc = (r_state != ST_FILL) && flush;
    end

    sat_counter #(.width(cnt_B)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_count)
    );

    sat_counter #(.width(cnt_B)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush_inc),
        .count (flush_count)
    );

    // Field decode works directly off the register so decode sees the
    // fields with no extra latency.
    always_comb begin
        PC_sumado_out   = r_pc;
        Instruction_out = r_instr;
        valid_out       = r_valid;
        opcode          = r_instr[OPCODE_MSB:OPCODE_LSB];
        rs              = r_instr[RS_MSB:RS_LSB];
        rt              = r_instr[RT_MSB:RT_LSB];
        rd              = r_instr[RD_MSB:RD_LSB];
        shamt           = r_instr[SHAMT_MSB:SHAMT_LSB];
        funct           = r_instr[FUNCT_MSB:FUNCT_LSB];
        imm_ext         = {{(width_B-16){r_instr[IMM_MSB]}}, r_instr[IMM_MSB:IMM_LSB]};
    end

endmodule

// File: tb/tb_ifid_stage.sv
// ---------------------------------------------------------------------------
// tb_ifid_stage
// Directed bench for ifid_stage. Two instances share the same stimulus: the
// default configuration and a 4-bit counter configuration for saturation.
// ---------------------------------------------------------------------------
module tb_ifid_stage;

    logic        clk;
    logic        reset;
    logic [31:0] PC_sumado;
    logic [31:0] Instruction;
    logic        IFID_write;
    logic        flush;

    logic [31:0] PC_sumado_out,   PC_sumado_out4;
    logic [31:0] Instruction_out, Instruction_out4;
    logic        valid_out,       valid_out4;
    logic [5:0]  opcode,  opcode4;
    logic [4:0]  rs, rt, rd, shamt;
    logic [4:0]  rs4, rt4, rd4, shamt4;
    logic [5:0]  funct,   funct4;
    logic [31:0] imm_ext, imm_ext4;
    logic [15:0] stall_count, flush_count;
    logic [3:0]  stall_count4, flush_count4;

    int checks   = 0;
    int failures = 0;

    ifid_stage #(.width_B(32), .cnt_B(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .PC_sumado       (PC_sumado),
        .Instruction     (Instruction),
        .IFID_write      (IFID_write),
        .flush           (flush),
        .PC_sumado_out   (PC_sumado_out),
        .Instruction_out (Instruction_out),
        .valid_out       (valid_out),
        .opcode          (opcode),
        .rs              (rs),
        .rt              (rt),
        .rd              (rd),
        .shamt           (shamt),
        .funct           (funct),
        .imm_ext         (imm_ext),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    ifid_stage #(.width_B(32), .cnt_B(4)) dut4 (
        .clk             (clk),
        .reset           (reset),
        .PC_sumado       (PC_sumado),
        .Instruction     (Instruction),
        .IFID_write      (IFID_write),
        .flush           (flush),
        .PC_sumado_out   (PC_sumado_out4),
        .Instruction_out (Instruction_out4),
        .valid_out       (valid_out4),
        .opcode          (opcode4),
        .rs              (rs4),
        .rt              (rt4),
        .rd              (rd4),
        .shamt           (shamt4),
        .funct           (funct4),
        .imm_ext         (imm_ext4),
        .stall_count     (stall_count4),
        .flush_count     (flush_count4)
    );

    // Falling edges at 10, 20, ...; sampling happens just after rising edges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one set of inputs, let one falling edge act on them, then sample
    // just after the following rising edge.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                                 input logic wr, input logic fl);
        PC_sumado   = pc;
        Instruction = instr;
        IFID_write  = wr;
        flush       = fl;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        PC_sumado   = 32'h0;
        Instruction = 32'h0;
        IFID_write  = 1'b0;
        flush       = 1'b0;

        // Reset state.
        #1;
        checkOutput("rst_instr", Instruction_out, 32'h0);
        checkOutput("rst_pc",    PC_sumado_out,   32'h0);
        checkOutput("rst_valid", {31'h0, valid_out}, 32'h0);
        checkOutput("rst_stall", {16'h0, stall_count}, 32'h0);
        checkOutput("rst_flush", {16'h0, flush_count}, 32'h0);
        #1 reset = 1'b0;

        // Priming edge with a flush request: flush ignored, bubble loaded.
        applyStimulus(32'h1, 32'h8C22_0004, 1'b1, 1'b1);
        checkOutput("fill_valid", {31'h0, valid_out}, 32'h0);
        checkOutput("fill_instr", Instruction_out, 32'h0);
        checkOutput("fill_pc",    PC_sumado_out,   32'h1);
        checkOutput("fill_flushcnt", {16'h0, flush_count}, 32'h0);

        // First real capture: lw-style word.
        applyStimulus(32'h2, 32'h8C22_0004, 1'b1, 1'b0);
        checkOutput("cap1_valid",  {31'h0, valid_out}, 32'h1);
        checkOutput("cap1_instr",  Instruction_out, 32'h8C22_0004);
        checkOutput("cap1_pc",     PC_sumado_out,   32'h2);
        checkOutput("cap1_opcode", {26'h0, opcode}, 32'h23);
        checkOutput("cap1_rs",     {27'h0, rs},     32'h1);
        checkOutput("cap1_rt",     {27'h0, rt},     32'h2);
        checkOutput("cap1_rd",     {27'h0, rd},     32'h0);
        checkOutput("cap1_funct",  {26'h0, funct},  32'h4);
        checkOutput("cap1_imm",    imm_ext,         32'h0000_0004);

        // Negative immediate.
        applyStimulus(32'h3, 32'h2001_FFFF, 1'b1, 1'b0);
        checkOutput("cap2_instr",  Instruction_out, 32'h2001_FFFF);
        checkOutput("cap2_opcode", {26'h0, opcode}, 32'h08);
        checkOutput("cap2_rt",     {27'h0, rt},     32'h1);
        checkOutput("cap2_rd",     {27'h0, rd},     32'h1F);
        checkOutput("cap2_shamt",  {27'h0, shamt},  32'h1F);
        checkOutput("cap2_funct",  {26'h0, funct},  32'h3F);
        checkOutput("cap2_imm",    imm_ext,         32'hFFFF_FFFF);

        // Three stalls with changing inputs: everything holds.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(32'h4 + k, 32'hDEAD_0000 + k, 1'b0, 1'b0);
            checkOutput("stall_instr", Instruction_out, 32'h2001_FFFF);
            checkOutput("stall_pc",    PC_sumado_out,   32'h3);
            checkOutput("stall_valid", {31'h0, valid_out}, 32'h1);
            checkOutput("stall_cnt",   {16'h0, stall_count}, k + 1);
            checkOutput("stall_cnt4",  {28'h0, stall_count4}, k + 1);
        end
        checkOutput("stall_imm", imm_ext, 32'hFFFF_FFFF);

        // Capture, then flush with IFID_write=0 from RUN.
        applyStimulus(32'h14, 32'h0000_1234, 1'b1, 1'b0);
        checkOutput("cap3_instr", Instruction_out, 32'h0000_1234);
        applyStimulus(32'h15, 32'hAAAA_AAAA, 1'b0, 1'b1);
        checkOutput("flush_instr", Instruction_out, 32'h0);
        checkOutput("flush_valid", {31'h0, valid_out}, 32'h0);
        checkOutput("flush_pc",    PC_sumado_out,   32'h14);
        checkOutput("flush_cnt",   {16'h0, flush_count}, 32'h1);
        checkOutput("flush_stall", {16'h0, stall_count}, 32'h3);

        // Stall while squashed: bubble held, stall counted.
        applyStimulus(32'h16, 32'h5555_5555, 1'b0, 1'b0);
        checkOutput("sq_hold_instr", Instruction_out, 32'h0);
        checkOutput("sq_hold_valid", {31'h0, valid_out}, 32'h0);
        checkOutput("sq_hold_stall", {16'h0, stall_count}, 32'h4);

        // Leaving SQUASH with a capture.
        applyStimulus(32'h17, 32'h0123_4567, 1'b1, 1'b0);
        checkOutput("resume_valid", {31'h0, valid_out}, 32'h1);
        checkOutput("resume_instr", Instruction_out, 32'h0123_4567);
        checkOutput("resume_pc",    PC_sumado_out,   32'h17);

        // Twenty stalls: the 4-bit counter saturates, the 16-bit one keeps going.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(32'h20 + k, 32'hBEEF_0000 + k, 1'b0, 1'b0);
        end
        checkOutput("sat_cnt4",   {28'h0, stall_count4}, 32'hF);
        checkOutput("sat_cnt16",  {16'h0, stall_count},  32'd24);
        checkOutput("sat_instr",  Instruction_out, 32'h0123_4567);
        checkOutput("sat_flush4", {28'h0, flush_count4}, 32'h1);

        // Reset pulse between edges while holding: immediate clear.
        reset = 1'b1;
        #1;
        checkOutput("midrst_instr", Instruction_out, 32'h0);
        checkOutput("midrst_pc",    PC_sumado_out,   32'h0);
        checkOutput("midrst_valid", {31'h0, valid_out}, 32'h0);
        checkOutput("midrst_stall", {16'h0, stall_count}, 32'h0);
        checkOutput("midrst_flush", {16'h0, flush_count}, 32'h0);
        checkOutput("midrst_imm",   imm_ext, 32'h0);
        // Inputs wiggle across a falling edge while reset is held.
        PC_sumado   = 32'h99;
        Instruction = 32'hFFFF_FFFF;
        IFID_write  = 1'b1;
        flush       = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("inrst_instr", Instruction_out, 32'h0);
        checkOutput("inrst_pc",    PC_sumado_out,   32'h0);
        checkOutput("inrst_valid", {31'h0, valid_out}, 32'h0);
        checkOutput("inrst_flush", {16'h0, flush_count}, 32'h0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // First post-reset edge is the priming edge again.
        applyStimulus(32'h30, 32'h1111_2222, 1'b1, 1'b0);
        checkOutput("post_fill_valid", {31'h0, valid_out}, 32'h0);
        checkOutput("post_fill_instr", Instruction_out, 32'h0);
        checkOutput("post_fill_pc",    PC_sumado_out,   32'h30);
        applyStimulus(32'h31, 32'h1111_2222, 1'b1, 1'b0);
        checkOutput("post_cap_valid", {31'h0, valid_out}, 32'h1);
        checkOutput("post_cap_instr", Instruction_out, 32'h1111_2222);
        checkOutput("post_cap_stall", {16'h0, stall_count}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifid_stage.md
IFID_STAGE -- requirements
Module: ifid_stage

Interface
REQ-001 Parameter: width_B, default 32, data/address width of fetched words.
REQ-002 Parameter: cnt_B, default 16, width of the debug event counters.
REQ-003 clk  input  1  single clock; all state updates on falling edge, aligned with PC update in fetch stage.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 PC_sumado  input  width_B  PC+1 from fetch stage.
REQ-006 Instruction  input  width_B  instruction word from instruction ROM.
REQ-007 IFID_write  input  1  hazard unit write enable; 0 = hold current contents (stall).
REQ-008 flush  input  1  branch/jump taken; discard instruction being captured.
REQ-009 PC_sumado_out  output  width_B  registered PC+1.
REQ-010 Instruction_out  output  width_B  registered instruction (NOP when invalid).
REQ-011 valid_out  output  1  registered instruction is real, not bubble.
REQ-012 opcode[5:0], rs[4:0], rt[4:0], rd[4:0], shamt[4:0], funct[5:0]  outputs  decoded fields of Instruction_out (bits 31:26, 25:21, 20:16, 15:11, 10:6, 5:0).
REQ-013 imm_ext  output  width_B  Instruction_out[15:0] sign-extended to width_B.
REQ-014 stall_count, flush_count  outputs  cnt_B  debug event counters.

Function
REQ-015 Field outputs and imm_ext SHALL be combinational functions of Instruction_out only; zero added latency.
REQ-016 FSM states SHALL be FILL, RUN, HOLD, SQUASH.
REQ-017 FILL: first falling edge after reset release SHALL load NOP, valid_out=0, PC_sumado_out=PC_sumado, then go to RUN (ROM priming cycle), regardless of IFID_write; flush in FILL SHALL be ignored.
REQ-018 RUN/HOLD/SQUASH, flush=1: SHALL load Instruction_out=NOP, valid_out=0, PC_sumado_out unchanged, go to SQUASH; flush SHALL take priority over IFID_write=0.
REQ-019 flush=0, IFID_write=0: all registers SHALL hold, go to HOLD.
REQ-020 flush=0, IFID_write=1: SHALL load Instruction, PC_sumado, valid_out=1, go to RUN.
REQ-021 SQUASH SHALL last exactly as long as no new capture occurs; leaving SQUASH follows REQ-018..020.
REQ-022 Latency input-to-output SHALL be one falling edge when IFID_write=1 and flush=0.
REQ-023 stall_count SHALL increment on each falling edge with flush=0, IFID_write=1'b0, state not FILL; saturate at all-ones.
REQ-024 flush_count SHALL increment on each falling edge with flush=1, state not FILL; saturate at all-ones.
REQ-025 Counter increments SHALL occur in same edge as the corresponding register action.

Reset
REQ-026 reset=1 SHALL immediately force state=FILL, Instruction_out=NOP (all zero), PC_sumado_out=0, valid_out=0, stall_count=0, flush_count=0.
REQ-027 Reset asserted mid-stall or mid-squash SHALL discard held contents; no residual valid.
REQ-028 Outputs SHALL not change while reset=1 irrespective of other inputs.

Structure
REQ-029 Shared package pipeline_pkg SHALL hold NOP constant, FSM state encoding, instruction field bit positions.
REQ-030 One sub-module sat_counter (parameter width, inputs clk/reset/inc, output count), instantiated twice.
REQ-031 Implementation SHALL not instantiate the ROM nor generate PC_next.

Verification
REQ-032 Reset released, Instruction=32'h8C22_0004, IFID_write=1 -> edge1 valid_out=0 Instruction_out=0; edge2 valid_out=1, Instruction_out=32'h8C22_0004, opcode=6'h23, rs=1, rt=2, imm_ext=32'h0000_0004.
REQ-033 Load 32'h2001_FFFF then IFID_write=0 for 3 edges while input changes -> outputs hold, imm_ext=32'hFFFF_FFFF, stall_count=3.
REQ-034 flush=1 with IFID_write=0 in RUN -> next edge Instruction_out=0, valid_out=0, PC_sumado_out unchanged, flush_count=1, stall_count unchanged.
REQ-035 flush=1 on edge right after reset release -> ignored, state RUN, flush_count=0.
REQ-036 cnt_B=4, hold IFID_write=0 for 20 edges -> stall_count=4'hF, no wrap.
REQ-037 reset pulse asserted between edges during HOLD -> outputs zero immediately, first post-reset capture valid_out=0.
